// File: rtl/disl_priority_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : disl_priority_decoder                                           |
// | Brief    : Index-to-one-hot decoder with sticky pending vector + popcount. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module disl_priority_decoder #(
  parameter  int WIDTH = 8,
  localparam int IW    = (WIDTH > 2) ? $clog2(WIDTH) : 1,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_index,
  input  logic             in_set,
  input  logic             clear_all,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_set,
  output logic [WIDTH-1:0] pending,
  output logic [CW-1:0]    pending_count,
  output logic             range_error
);

  logic             w_accept;
  logic             w_in_range;
  logic             w_load;
  logic [WIDTH-1:0] w_onehot;
  logic [WIDTH-1:0] w_pending_nxt;
  logic [CW-1:0]    w_count_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_onehot;
  logic             r_out_set;
  logic [WIDTH-1:0] r_pending;
  logic [CW-1:0]    r_pending_count;
  logic             r_range_error;

  assign in_ready = ~reset & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_accept & w_in_range;

  // Every index encodable in IW bits is legal when WIDTH is a power of two.
  generate
    if (WIDTH == (1 << IW)) begin : g_pow2
      assign w_in_range = 1'b1;
    end else begin : g_npow2
      localparam logic [IW:0] c_WIDTH_EXT = (IW + 1)'(WIDTH);
      assign w_in_range = ({1'b0, in_index} < c_WIDTH_EXT);
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign w_onehot[gi] = (in_index == IW'(gi));
    end
  endgenerate

  always_comb begin
    w_pending_nxt = r_pending;
    if (clear_all) begin
      w_pending_nxt = '0;
    end else if (w_load) begin
      w_pending_nxt = in_set ? (r_pending | w_onehot) : (r_pending & ~w_onehot);
    end
  end

  // Count is taken from the next-state vector so it lands with pending.
  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_count_nxt = w_count_nxt + CW'(w_pending_nxt[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid     <= 1'b0;
      r_out_onehot    <= '0;
      r_out_set       <= 1'b0;
      r_pending       <= '0;
      r_pending_count <= '0;
      r_range_error   <= 1'b0;
    end else begin
      r_pending       <= w_pending_nxt;
      r_pending_count <= w_count_nxt;
      r_range_error   <= w_accept & ~w_in_range;
      if (w_load) begin
        r_out_valid  <= 1'b1;
        r_out_onehot <= w_onehot;
        r_out_set    <= in_set;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_onehot    = r_out_onehot;
  assign out_set       = r_out_set;
  assign pending       = r_pending;
  assign pending_count = r_pending_count;
  assign range_error   = r_range_error;

endmodule
`default_nettype wire

// File: tb/tb_disl_priority_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_disl_priority_decoder                                        |
// | Brief    : Directed self-checking bench, WIDTH=8 and WIDTH=6 instances.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_disl_priority_decoder;

  logic clock;
  logic reset;

  // WIDTH=8 instance (IW=3, CW=4)
  logic       a_in_valid, a_in_ready, a_in_set, a_clear_all;
  logic [2:0] a_in_index;
  logic       a_out_valid, a_out_ready, a_out_set, a_range_error;
  logic [7:0] a_out_onehot, a_pending;
  logic [3:0] a_pending_count;

  // WIDTH=6 instance (IW=3, CW=3)
  logic       b_in_valid, b_in_ready, b_in_set, b_clear_all;
  logic [2:0] b_in_index;
  logic       b_out_valid, b_out_ready, b_out_set, b_range_error;
  logic [5:0] b_out_onehot, b_pending;
  logic [2:0] b_pending_count;

  int n_pass  = 0;
  int n_total = 0;

  disl_priority_decoder #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_index(a_in_index),
    .in_set(a_in_set), .clear_all(a_clear_all),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_onehot(a_out_onehot),
    .out_set(a_out_set), .pending(a_pending), .pending_count(a_pending_count),
    .range_error(a_range_error)
  );

  disl_priority_decoder #(.WIDTH(6)) u_dut6 (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_index(b_in_index),
    .in_set(b_in_set), .clear_all(b_clear_all),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_onehot(b_out_onehot),
    .out_set(b_out_set), .pending(b_pending), .pending_count(b_pending_count),
    .range_error(b_range_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_in_valid = 1'b1; a_in_index = 3'd5; a_in_set = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++; if (a_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", a_in_ready); else n_pass++;
      n_total++; if (a_pending !== 8'h00) $display("FAIL reset_pending: got %h want 00", a_pending); else n_pass++;
      n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", a_out_valid); else n_pass++;
    end
    n_total++; if (a_pending_count !== 4'd0 || a_range_error !== 1'b0 || a_out_onehot !== 8'h00 || a_out_set !== 1'b0)
      $display("FAIL reset_misc: cnt=%0d rerr=%b oh=%h set=%b want 0/0/00/0", a_pending_count, a_range_error, a_out_onehot, a_out_set);
    else n_pass++;
    reset = 1'b0;
    a_in_valid = 1'b0;
    #1;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", a_in_ready); else n_pass++;
    step();
  endtask

  task automatic test_streaming();
    logic [2:0] idx [4];
    logic [7:0] exp [4];
    idx = '{3'd0, 3'd3, 3'd7, 3'd3};
    exp = '{8'h01, 8'h08, 8'h80, 8'h08};
    a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1'b1; a_in_index = idx[k]; a_in_set = 1'b1;
      step();
      n_total++; if (a_out_valid !== 1'b1 || a_out_onehot !== exp[k])
        $display("FAIL stream_beat%0d: valid=%b oh=%h want 1/%h", k, a_out_valid, a_out_onehot, exp[k]);
      else n_pass++;
    end
    a_in_valid = 1'b0;
    n_total++; if (a_pending !== 8'h89) $display("FAIL stream_pending: got %h want 89", a_pending); else n_pass++;
    n_total++; if (a_pending_count !== 4'd3) $display("FAIL stream_count: got %0d want 3", a_pending_count); else n_pass++;
    step();
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_index = 3'd2; a_in_set = 1'b1;
    step();
    a_in_index = 3'd6;
    for (int c = 0; c < 4; c++) begin
      n_total++; if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready%0d: got %b want 0", c, a_in_ready); else n_pass++;
      step();
      n_total++; if (a_out_valid !== 1'b1 || a_out_onehot !== 8'h04)
        $display("FAIL bp_hold%0d: valid=%b oh=%h want 1/04", c, a_out_valid, a_out_onehot);
      else n_pass++;
    end
    a_out_ready = 1'b1;
    #1;
    n_total++; if (a_in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", a_in_ready); else n_pass++;
    step();
    n_total++; if (a_out_valid !== 1'b1 || a_out_onehot !== 8'h40)
      $display("FAIL bp_reload: valid=%b oh=%h want 1/40", a_out_valid, a_out_onehot);
    else n_pass++;
    a_in_valid = 1'b0;
    n_total++; if (a_pending !== 8'hCD || a_pending_count !== 4'd5)
      $display("FAIL bp_pending: got %h/%0d want CD/5", a_pending, a_pending_count);
    else n_pass++;
    step();
  endtask

  task automatic test_clear();
    a_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_in_valid = 1'b1; a_in_index = 3'(k); a_in_set = 1'b1;
      step();
    end
    n_total++; if (a_pending !== 8'hFF || a_pending_count !== 4'd8)
      $display("FAIL clr_full: got %h/%0d want FF/8", a_pending, a_pending_count);
    else n_pass++;
    a_in_index = 3'd4; a_in_set = 1'b0;
    step();
    n_total++; if (a_pending !== 8'hEF || a_pending_count !== 4'd7)
      $display("FAIL clr_one: got %h/%0d want EF/7", a_pending, a_pending_count);
    else n_pass++;
    n_total++; if (a_out_onehot !== 8'h10 || a_out_set !== 1'b0)
      $display("FAIL clr_one_beat: oh=%h set=%b want 10/0", a_out_onehot, a_out_set);
    else n_pass++;
    a_in_index = 3'd1; a_in_set = 1'b1; a_clear_all = 1'b1;
    step();
    a_in_valid = 1'b0; a_clear_all = 1'b0;
    n_total++; if (a_pending !== 8'h00 || a_pending_count !== 4'd0)
      $display("FAIL clr_all: got %h/%0d want 00/0", a_pending, a_pending_count);
    else n_pass++;
    n_total++; if (a_out_valid !== 1'b1 || a_out_onehot !== 8'h02 || a_out_set !== 1'b1)
      $display("FAIL clr_all_beat: valid=%b oh=%h set=%b want 1/02/1", a_out_valid, a_out_onehot, a_out_set);
    else n_pass++;
    step();
  endtask

  task automatic test_range_error();
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_index = 3'd0; b_in_set = 1'b1;
    step();
    n_total++; if (b_out_onehot !== 6'h01 || b_range_error !== 1'b0)
      $display("FAIL rng_first: oh=%h rerr=%b want 01/0", b_out_onehot, b_range_error);
    else n_pass++;
    b_in_index = 3'd6;
    step();
    n_total++; if (b_range_error !== 1'b1 || b_out_valid !== 1'b0 || b_pending !== 6'h01)
      $display("FAIL rng_idx6: rerr=%b valid=%b pend=%h want 1/0/01", b_range_error, b_out_valid, b_pending);
    else n_pass++;
    b_in_index = 3'd7;
    step();
    n_total++; if (b_range_error !== 1'b1 || b_out_valid !== 1'b0 || b_pending !== 6'h01)
      $display("FAIL rng_idx7: rerr=%b valid=%b pend=%h want 1/0/01", b_range_error, b_out_valid, b_pending);
    else n_pass++;
    b_in_index = 3'd5;
    step();
    b_in_valid = 1'b0;
    n_total++; if (b_range_error !== 1'b0 || b_out_valid !== 1'b1 || b_out_onehot !== 6'h20)
      $display("FAIL rng_idx5: rerr=%b valid=%b oh=%h want 0/1/20", b_range_error, b_out_valid, b_out_onehot);
    else n_pass++;
    n_total++; if (b_pending !== 6'h21 || b_pending_count !== 3'd2)
      $display("FAIL rng_pending: got %h/%0d want 21/2", b_pending, b_pending_count);
    else n_pass++;
    step();
    n_total++; if (b_range_error !== 1'b0) $display("FAIL rng_pulse_end: got %b want 0", b_range_error); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    a_out_ready = 1'b1;
    a_clear_all = 1'b1;
    step();
    a_clear_all = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1'b1; a_in_index = 3'(k); a_in_set = 1'b1;
      step();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    step();
    n_total++; if (a_out_valid !== 1'b1 || a_pending !== 8'h0F || a_pending_count !== 4'd4)
      $display("FAIL stall_setup: valid=%b pend=%h cnt=%0d want 1/0F/4", a_out_valid, a_pending, a_pending_count);
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_total++; if (a_out_valid !== 1'b0 || a_pending !== 8'h00 || a_pending_count !== 4'd0)
      $display("FAIL stall_reset: valid=%b pend=%h cnt=%0d want 0/00/0", a_out_valid, a_pending, a_pending_count);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_index = 3'd0; a_in_set = 1'b0; a_clear_all = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_index = 3'd0; b_in_set = 1'b0; b_clear_all = 1'b0; b_out_ready = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_clear();
    test_range_error();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
